// File: rtl/beam_scan_if.sv
// beam_scan_if
//   Groups the sequencer's control, configuration and beam-handshake signals.
//   master: the sequencer side (drives the datapath strobes and status).
//   slave : the environment side (drives enable, config, ready and clear).
//   Signals:
//     en, pdm_clk, wr_en, wr_ptr, rd_ch, rd_addr, acc_clr, acc_en,
//     cfg_we, cfg_ch, cfg_delay, out_valid, out_ready, busy, overrun, overrun_clr
interface beam_scan_if #(
  parameter int NUM_CH = 16,
  parameter int DLY_W  = 5
);
  localparam int CH_W = $clog2(NUM_CH);

  logic             en;
  logic             pdm_clk;
  logic             wr_en;
  logic [DLY_W-1:0] wr_ptr;
  logic [CH_W-1:0]  rd_ch;
  logic [DLY_W-1:0] rd_addr;
  logic             acc_clr;
  logic             acc_en;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DLY_W-1:0] cfg_delay;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             overrun_clr;

  modport master (
    input  en, cfg_we, cfg_ch, cfg_delay, out_ready, overrun_clr,
    output pdm_clk, wr_en, wr_ptr, rd_ch, rd_addr, acc_clr, acc_en,
           out_valid, busy, overrun
  );

  modport slave (
    output en, cfg_we, cfg_ch, cfg_delay, out_ready, overrun_clr,
    input  pdm_clk, wr_en, wr_ptr, rd_ch, rd_addr, acc_clr, acc_en,
           out_valid, busy, overrun
  );
endinterface

// File: rtl/beam_scan_sequencer.sv
// beam_scan_sequencer
//   Sequencer for the delay-and-sum beamformer. Divides clk down to the PDM
//   mic clock and, once per PDM period, writes a delay-line column, scans all
//   channels through the shared accumulator at steered read addresses, then
//   offers the beam sample downstream. Steering delays are double-buffered.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     bus    beam_scan_if.master (control strobes, config, handshake, status)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a PDM sample tick
//   CAPTURE | write column at P, latch frame base, commit pending delays
//   SCAN    | one channel per cycle into the accumulator
//   EMIT    | out_valid held until downstream accepts
module beam_scan_sequencer #(
  parameter int NUM_CH  = 16,
  parameter int DLY_W   = 5,
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  beam_scan_if.master bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, EMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic             pdm_q;
  logic             div_wrap;
  logic             tick;

  logic [DLY_W-1:0] pend_dly [NUM_CH];
  logic [DLY_W-1:0] act_dly  [NUM_CH];
  logic             pend_dirty;
  logic             capture;
  logic [DLY_W-1:0] dly_ch0;

  logic [DLY_W-1:0] ptr_q;
  logic [DLY_W-1:0] base_q;
  logic [DLY_W-1:0] wr_ptr_q;
  logic             wr_en_q;
  logic [CH_W-1:0]  rd_ch_q;
  logic [CH_W-1:0]  nxt_ch;
  logic [DLY_W-1:0] rd_addr_q;
  logic             acc_clr_q;
  logic             acc_en_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             overrun_q;

  // Tick marks the wrap on which pdm_clk falls.
  assign div_wrap = bus.en && (div_cnt == CNT_W'(CLK_DIV - 1));
  assign tick     = div_wrap && pdm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pdm_q   <= 1'b0;
    end else if (!bus.en) begin
      div_cnt <= '0;
      pdm_q   <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      pdm_q   <= ~pdm_q;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign capture = (state == CAPTURE);

  // A write landing in the CAPTURE cycle keeps dirty set so it commits next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) pend_dly[i] <= '0;
      pend_dirty <= 1'b0;
    end else begin
      if (bus.cfg_we) pend_dly[bus.cfg_ch] <= bus.cfg_delay;
      if (bus.cfg_we)   pend_dirty <= 1'b1;
      else if (capture) pend_dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) act_dly[i] <= '0;
    end else if (capture && pend_dirty) begin
      for (int i = 0; i < NUM_CH; i++) act_dly[i] <= pend_dly[i];
    end
  end

  // Channel 0 address is formed during CAPTURE, before the bank copy lands.
  assign dly_ch0 = pend_dirty ? pend_dly[0] : act_dly[0];
  assign nxt_ch  = rd_ch_q + CH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr_q       <= '0;
      base_q      <= '0;
      wr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      rd_ch_q     <= '0;
      rd_addr_q   <= '0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      acc_clr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= CAPTURE;
            wr_en_q  <= 1'b1;
            wr_ptr_q <= ptr_q;
            busy_q   <= 1'b1;
          end
        end
        CAPTURE: begin
          state     <= SCAN;
          base_q    <= ptr_q;
          ptr_q     <= ptr_q + DLY_W'(1);
          rd_ch_q   <= '0;
          rd_addr_q <= ptr_q - dly_ch0;
          acc_en_q  <= 1'b1;
          acc_clr_q <= 1'b1;
        end
        SCAN: begin
          if (rd_ch_q == CH_W'(NUM_CH - 1)) begin
            state       <= EMIT;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            rd_ch_q   <= nxt_ch;
            rd_addr_q <= base_q - act_dly[nxt_ch];
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // A new overrun event beats a simultaneous clear.
      if (tick && (state != IDLE)) overrun_q <= 1'b1;
      else if (bus.overrun_clr)    overrun_q <= 1'b0;
    end
  end

  assign bus.pdm_clk   = pdm_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.rd_ch     = rd_ch_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_beam_scan_sequencer.sv
module tb_beam_scan_sequencer;
  localparam int NUM_CH  = 16;
  localparam int DLY_W   = 5;
  localparam int CLK_DIV = 16;
  localparam int CH_W    = 4;
  localparam int PMASK   = (1 << DLY_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beam_scan_if #(.NUM_CH(NUM_CH), .DLY_W(DLY_W)) bus ();

  beam_scan_sequencer #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .CLK_DIV(CLK_DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int ch;
    int addr;
    int clr;
  } rd_exp_t;

  rd_exp_t exp_rd[$];
  int      exp_wr[$];
  int      errs = 0;
  int      checks = 0;

  int mp;
  int m_act [NUM_CH];
  int m_pend[NUM_CH];
  bit m_dirty;

  task automatic check_eq(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag_fail(string name, string what);
    checks++;
    errs++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic int outvec();
    return int'({bus.pdm_clk, bus.wr_en, bus.wr_ptr, bus.rd_ch, bus.rd_addr,
                 bus.acc_clr, bus.acc_en, bus.out_valid, bus.busy, bus.overrun});
  endfunction

  // Reference: one frame at write pointer mp using the committed delays.
  task automatic expect_frame();
    rd_exp_t e;
    if (m_dirty) begin
      m_act   = m_pend;
      m_dirty = 1'b0;
    end
    exp_wr.push_back(mp);
    for (int i = 0; i < NUM_CH; i++) begin
      e.ch   = i;
      e.addr = (mp - m_act[i]) & PMASK;
      e.clr  = (i == 0) ? 1 : 0;
      exp_rd.push_back(e);
    end
    mp = (mp + 1) & PMASK;
  endtask

  task automatic model_reset();
    mp = 0;
    m_dirty = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i]  = 0;
      m_pend[i] = 0;
    end
  endtask

  // Called at a negedge; cfg_we is seen by exactly one posedge.
  task automatic cfg_write(int ch, int d);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_delay = DLY_W'(d);
    m_pend[ch]    = d;
    m_dirty       = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  function automatic bit hit(int mode, int ch);
    case (mode)
      0:       return bus.out_valid && bus.out_ready;
      1:       return bus.out_valid;
      2:       return bus.acc_en && (int'(bus.rd_ch) == ch);
      default: return bus.wr_en;
    endcase
  endfunction

  // mode 0: handshake (returns after it completes), 1: out_valid, 2: scan of ch, 3: wr_en
  task automatic wait_for(int mode, int ch, string name);
    int n;
    n = 0;
    while (!hit(mode, ch) && n < 150) begin
      @(negedge clk);
      n++;
    end
    if (!hit(mode, ch)) flag_fail(name, "timed out waiting for event");
    else if (mode == 0) @(negedge clk);
  endtask

  // Monitor / scoreboard
  int cyc = 0;
  bit rdy_edge;
  int last_fall = -1;
  int wr_cyc = -100;
  int acc_cnt = 0;
  bit pdm_prev, ov_prev;
  bit period_chk = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rdy_edge = bus.out_ready;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_fall = -1;
      acc_cnt   = 0;
      pdm_prev  = 1'b0;
      ov_prev   = 1'b0;
    end else begin
      if (pdm_prev && !bus.pdm_clk) begin
        if (period_chk && last_fall >= 0) check_eq("pdm_period", cyc - last_fall, 2 * CLK_DIV);
        last_fall = cyc;
      end
      pdm_prev = bus.pdm_clk;

      if (bus.wr_en) begin
        check_eq("wr_at_tick", cyc, last_fall);
        if (exp_wr.size() == 0) begin
          $display("FAIL unexpected_wr_en: got write at wr_ptr=%0d, expected none", bus.wr_ptr);
          checks++;
          errs++;
        end else begin
          check_eq("wr_ptr", int'(bus.wr_ptr), exp_wr.pop_front());
        end
        wr_cyc = cyc;
      end

      if (bus.acc_en) begin
        if (exp_rd.size() == 0) begin
          $display("FAIL unexpected_acc_en: got rd_ch=%0d, expected none", bus.rd_ch);
          checks++;
          errs++;
        end else begin
          rd_exp_t e;
          e = exp_rd.pop_front();
          check_eq("rd_ch", int'(bus.rd_ch), e.ch);
          check_eq($sformatf("rd_addr_ch%0d", e.ch), int'(bus.rd_addr), e.addr);
          check_eq("acc_clr", int'(bus.acc_clr), e.clr);
        end
        acc_cnt = bus.acc_clr ? 1 : acc_cnt + 1;
      end else if (bus.acc_clr) begin
        flag_fail("acc_clr_alone", "acc_clr high without acc_en");
      end

      if (bus.out_valid && !ov_prev) begin
        check_eq("valid_latency", cyc - wr_cyc, NUM_CH + 1);
        check_eq("acc_count", acc_cnt, NUM_CH);
      end
      if (ov_prev && !rdy_edge && !bus.out_valid)
        flag_fail("out_valid_hold", "out_valid dropped without out_ready");
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en          = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_delay   = '0;
    bus.out_ready   = 1'b0;
    bus.overrun_clr = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", outvec(), 0);

    // Free-running frames: pointer wrap, steering with wrap, mid-scan and capture-cycle config
    rst_n         = 1'b1;
    bus.en        = 1'b1;
    bus.out_ready = 1'b1;
    period_chk    = 1'b1;
    for (int f = 0; f < 33; f++) begin
      expect_frame();
      if (f == 6) begin
        wait_for(2, 5, "scan_ch5_f6");
        cfg_write(0, 4);
      end
      if (f == 10) begin
        wait_for(3, 0, "capture_f10");
        cfg_write(9, 2);
      end
      wait_for(0, 0, $sformatf("handshake_f%0d", f));
      if (f == 1)  cfg_write(3, 7);
      if (f == 2)  cfg_write(3, 0);
      if (f == 7)  cfg_write(0, 0);
      if (f == 11) cfg_write(9, 0);
    end

    // Backpressure: out_valid held, tick dropped as overrun, pointer frozen
    period_chk    = 1'b0;
    bus.out_ready = 1'b0;
    expect_frame();
    wait_for(1, 0, "valid_stalled");
    repeat (40) @(negedge clk);
    check_eq("held_valid", int'(bus.out_valid), 1);
    check_eq("overrun_set", int'(bus.overrun), 1);
    check_eq("wr_ptr_frozen", int'(bus.wr_ptr), 1);
    check_eq("busy_in_emit", int'(bus.busy), 1);
    bus.out_ready = 1'b1;
    expect_frame();
    wait_for(0, 0, "handshake_release");
    check_eq("overrun_sticky", int'(bus.overrun), 1);
    check_eq("busy_after_emit", int'(bus.busy), 0);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check_eq("overrun_cleared", int'(bus.overrun), 0);
    wait_for(0, 0, "handshake_after_overrun");

    // en dropped mid-frame: frame finishes, then no clock and no frames
    expect_frame();
    wait_for(2, 3, "scan_ch3_en");
    bus.en = 1'b0;
    wait_for(0, 0, "handshake_en_off");
    repeat (100) @(negedge clk);
    check_eq("pdm_off", int'(bus.pdm_clk), 0);
    check_eq("busy_off", int'(bus.busy), 0);
    check_eq("no_overrun_off", int'(bus.overrun), 0);
    bus.en = 1'b1;

    // Reset during SCAN: outputs clear at once, delays and pointer restart
    cfg_write(1, 3);
    expect_frame();
    wait_for(2, 7, "scan_ch7_rst");
    #2;
    rst_n = 1'b0;
    exp_rd.delete();
    #1;
    check_eq("async_reset_outputs", outvec(), 0);
    check_eq("wr_queue_at_reset", exp_wr.size(), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_frame();
    wait_for(0, 0, "handshake_after_reset");
    repeat (5) @(negedge clk);
    check_eq("rd_queue_drained", exp_rd.size(), 0);
    check_eq("wr_queue_drained", exp_wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
